// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: width helpers and the
// per-cycle selection decision type.
package rr_fifo_arbiter_pkg;

  // Index width for n sources. It is never below one bit, so a degenerate
  // count still yields a legal vector.
  function automatic int unsigned srcid_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Burst counter width. One bit wider than clog2(burst), so the counter can
  // hold burst-1 and compare against it without wrapping.
  function automatic int unsigned burst_w(input int unsigned burst);
    return ((burst <= 1) ? 0 : $clog2(burst)) + 1;
  endfunction

  // What the arbiter does on the current cycle.
  typedef enum logic [1:0] {
    PICK_NONE,    // no grant: stalled, or nothing valid
    PICK_KEEP,    // stay on the current owner within its burst allowance
    PICK_ROTATE   // move to the next valid source after the owner
  } pick_e;

endpackage

// File: rtl/rr_fifo_arbiter_if.sv
// Bundle of the arbiter's source-facing and downstream-facing signals.
// "slave" is the arbiter's view; "master" is the environment driving the
// sources and the downstream accept.
interface rr_fifo_arbiter_if
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 64
);

  localparam int ID_W = srcid_w(N);

  logic [N-1:0]       i_Valid;   // per-source o_Valid
  logic [N*WIDTH-1:0] i_Data;    // source k at [k*WIDTH +: WIDTH]
  logic [N-1:0]       o_Grant;   // pop to source k
  logic               o_Valid;   // merged stream valid
  logic [WIDTH-1:0]   o_Data;    // merged stream data
  logic [ID_W-1:0]    o_SrcId;   // source that produced o_Data
  logic               i_Grant;   // downstream accept

  modport slave (
    input  i_Valid, i_Data, i_Grant,
    output o_Grant, o_Valid, o_Data, o_SrcId
  );

  modport master (
    output i_Valid, i_Data, i_Grant,
    input  o_Grant, o_Valid, o_Data, o_SrcId
  );

endinterface

// File: rtl/rr_fifo_arbiter_priority_pick.sv
// Rotated priority encoder. It finds the first asserted req, searching from
// base+1 upward and wrapping mod N. Base itself is examined last.
module rr_priority_pick
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = srcid_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Walk the candidates from farthest to nearest so the nearest hit is the
  // last one written.
  always_comb begin
    // NOTE: every output gets a default before any branch; a path that skips
    // an assignment would infer a latch.
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N; k >= 1; k--) begin
      pos = IDX_W'((int'(base) + k) % N);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Consumer side of the bypass-FIFO grant protocol. Arbitrates N sources
// round-robin, with an optional burst hold on the current owner. It pops the
// winner through o_Grant and registers the winning beat into one output
// stream. Downstream uses the same grant semantics.
module rr_fifo_arbiter
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 64,
  parameter int BURST = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  rr_fifo_arbiter_if.slave  bus
);

  localparam int ID_W  = srcid_w(N);
  localparam int CNT_W = burst_w(BURST);

  logic [ID_W-1:0]  owner;       // source granted most recently
  logic [CNT_W-1:0] burst_cnt;   // extra consecutive grants given to owner
  logic             load_en;     // output register may take a new beat
  logic             any_valid;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  sel;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] sel_data;
  pick_e            decision;

  rr_priority_pick #(.N(N)) u_pick (
    .req   (bus.i_Valid),
    .base  (owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Decide keep/rotate/none for this cycle and form the one-hot pop.
  always_comb begin
    load_en   = ~bus.o_Valid | bus.i_Grant;
    any_valid = |bus.i_Valid;
    decision  = PICK_NONE;
    sel       = owner;
    grant     = '0;
    if (!Reset && load_en && any_valid) begin
      if (bus.i_Valid[owner] && (burst_cnt < CNT_W'(BURST - 1))) begin
        decision = PICK_KEEP;
      end else if (pick_found) begin
        decision = PICK_ROTATE;
        sel      = pick_idx;
      end
    end
    if (decision != PICK_NONE) begin
      grant[sel] = 1'b1;
    end
  end

  assign bus.o_Grant = grant;

  // Route the selected source's beat to the output register.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == ID_W'(k)) begin
        sel_data = bus.i_Data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output register stage and round-robin state. All of it holds while
  // downstream stalls.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments throughout, so every register here
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      bus.o_Valid <= 1'b0;
      bus.o_Data  <= '0;
      bus.o_SrcId <= '0;
      owner       <= ID_W'(N - 1);
      burst_cnt   <= '0;
    end else begin
      unique case (decision)
        PICK_KEEP: begin
          bus.o_Valid <= 1'b1;
          bus.o_Data  <= sel_data;
          bus.o_SrcId <= sel;
          burst_cnt   <= burst_cnt + CNT_W'(1);
        end
        PICK_ROTATE: begin
          bus.o_Valid <= 1'b1;
          bus.o_Data  <= sel_data;
          bus.o_SrcId <= sel;
          owner       <= sel;
          burst_cnt   <= '0;
        end
        default: begin
          // Free slot with nothing to fill it: the beat was taken, so drop
          // valid. When stalled, everything holds.
          if (load_en) begin
            bus.o_Valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed and scoreboarded checks for rr_fifo_arbiter. It uses two instances:
// pure round-robin (BURST=1) and burst hold (BURST=3).
module tb_rr_fifo_arbiter;
  import rr_fifo_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic rst1;
  logic rst3;

  always #5 CLK = ~CLK;

  rr_fifo_arbiter_if #(.N(N), .WIDTH(W)) bus1 ();
  rr_fifo_arbiter_if #(.N(N), .WIDTH(W)) bus3 ();

  rr_fifo_arbiter #(.N(N), .WIDTH(W), .BURST(1)) dut1 (
    .CLK   (CLK),
    .Reset (rst1),
    .bus   (bus1)
  );

  rr_fifo_arbiter #(.N(N), .WIDTH(W), .BURST(3)) dut3 (
    .CLK   (CLK),
    .Reset (rst3),
    .bus   (bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus for the BURST=1 instance plus its expected view.
  // exp_grant is the combinational pop in that cycle. exp_ov and exp_id are
  // the register contents in that cycle.
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       dgrant;
    logic       chk_out;
    logic [3:0] exp_grant;
    logic       exp_ov;
    logic [1:0] exp_id;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic dgrant,
                              input logic chk_out, input logic [3:0] exp_grant,
                              input logic exp_ov, input logic [1:0] exp_id);
    vec_t v;
    v.rst = rst; v.valid = valid; v.dgrant = dgrant; v.chk_out = chk_out;
    v.exp_grant = exp_grant; v.exp_ov = exp_ov; v.exp_id = exp_id;
    return v;
  endfunction

  function automatic int oh_to_idx(input logic [3:0] oh);
    for (int k = 0; k < 4; k++) if (oh[k]) return k;
    return 0;
  endfunction

  vec_t vecs[26];
  logic [4*W-1:0] const_data;

  // Random-phase scoreboard state.
  int         pops[N];
  int         outs[N];
  int         starve[N];
  int         max_starve;
  int         total_out;
  logic [N-1:0] rv;
  logic [N-1:0] rg;
  logic [3:0] bv[9];
  logic [3:0] bg[9];

  initial begin
    const_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.i_Valid = '0; bus1.i_Data = const_data; bus1.i_Grant = 1'b0;
    bus3.i_Valid = '0; bus3.i_Data = '0;         bus3.i_Grant = 1'b0;

    // Reset, round-robin, idle, sparse/wrap, backpressure, mid-stream reset.
    vecs[0]  = mk(1, 4'b1111, 1, 0, 4'b0000, 0, 0);
    vecs[1]  = mk(1, 4'b1111, 1, 1, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 4'b1111, 1, 1, 4'b0001, 0, 0);
    vecs[3]  = mk(0, 4'b1111, 1, 1, 4'b0010, 1, 0);
    vecs[4]  = mk(0, 4'b1111, 1, 1, 4'b0100, 1, 1);
    vecs[5]  = mk(0, 4'b1111, 1, 1, 4'b1000, 1, 2);
    vecs[6]  = mk(0, 4'b1111, 1, 1, 4'b0001, 1, 3);
    vecs[7]  = mk(0, 4'b1111, 1, 1, 4'b0010, 1, 0);
    vecs[8]  = mk(0, 4'b0000, 1, 1, 4'b0000, 1, 1);
    vecs[9]  = mk(0, 4'b0100, 1, 1, 4'b0100, 0, 1);
    vecs[10] = mk(0, 4'b0011, 1, 1, 4'b0001, 1, 2);
    vecs[11] = mk(0, 4'b0011, 1, 1, 4'b0010, 1, 0);
    vecs[12] = mk(0, 4'b0100, 1, 1, 4'b0100, 1, 1);
    vecs[13] = mk(0, 4'b0100, 1, 1, 4'b0100, 1, 2);
    vecs[14] = mk(0, 4'b0100, 1, 1, 4'b0100, 1, 2);
    for (int i = 15; i <= 19; i++) vecs[i] = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2);
    vecs[20] = mk(0, 4'b1111, 1, 1, 4'b1000, 1, 2);
    vecs[21] = mk(0, 4'b0000, 1, 1, 4'b0000, 1, 3);
    vecs[22] = mk(0, 4'b0001, 0, 1, 4'b0001, 0, 3);
    vecs[23] = mk(1, 4'b1111, 0, 1, 4'b0000, 1, 0);
    vecs[24] = mk(0, 4'b0000, 0, 1, 4'b0000, 0, 0);
    vecs[25] = mk(0, 4'b1111, 1, 1, 4'b0001, 0, 0);

    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      rst1         = vecs[i].rst;
      bus1.i_Valid = vecs[i].valid;
      bus1.i_Grant = vecs[i].dgrant;
      // Scramble source data while stalled; the held beat must not follow it.
      if (i >= 15 && i <= 19) bus1.i_Data = {$urandom, $urandom};
      else                    bus1.i_Data = const_data;
      #1;
      check($sformatf("v%0d_grant", i), bus1.o_Grant, vecs[i].exp_grant);
      if (vecs[i].chk_out) begin
        check($sformatf("v%0d_valid", i), bus1.o_Valid, vecs[i].exp_ov);
        check($sformatf("v%0d_srcid", i), bus1.o_SrcId, vecs[i].exp_id);
        if (vecs[i].exp_ov)
          check($sformatf("v%0d_data", i), bus1.o_Data, 16'hD000 | 16'(vecs[i].exp_id));
      end
      if (i == 1 || i == 24) check($sformatf("v%0d_rst_data", i), bus1.o_Data, 0);
    end

    // Burst hold on BURST=3: 0,0,0,1,1,1,0, then source 0 drops after two
    // beats and the grant moves to 1 at once.
    for (int j = 0; j < 8; j++) bv[j] = 4'b0011;
    bv[8] = 4'b0010;
    bg[0] = 4'b0001; bg[1] = 4'b0001; bg[2] = 4'b0001; bg[3] = 4'b0010; bg[4] = 4'b0010;
    bg[5] = 4'b0010; bg[6] = 4'b0001; bg[7] = 4'b0001; bg[8] = 4'b0010;
    @(negedge CLK); rst3 = 1'b1;
    @(negedge CLK); rst3 = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge CLK);
      rst3 = 1'b0;
      bus3.i_Valid = bv[j];
      bus3.i_Grant = 1'b1;
      #1;
      check($sformatf("burst%0d_grant", j), bus3.o_Grant, bg[j]);
      if (j > 0) begin
        check($sformatf("burst%0d_valid", j), bus3.o_Valid, 1);
        check($sformatf("burst%0d_srcid", j), bus3.o_SrcId, oh_to_idx(bg[j-1]));
      end
    end

    // Randomised stream with FIFO-like sources: a valid source stays valid
    // until popped. Tagged {src, seq} data gives order and loss checks.
    @(negedge CLK); rst3 = 1'b1; bus3.i_Valid = '0;
    for (int k = 0; k < N; k++) begin pops[k] = 0; outs[k] = 0; starve[k] = 0; end
    max_starve = 0;
    rv = 4'($urandom);
    for (int cyc = 0; cyc < 3004; cyc++) begin
      @(negedge CLK);
      rst3 = 1'b0;
      if (cyc >= 3000) rv = '0;
      for (int k = 0; k < N; k++) bus3.i_Data[k*W +: W] = {4'(k), 12'(pops[k])};
      bus3.i_Valid = rv;
      bus3.i_Grant = (cyc >= 3000) ? 1'b1 : (($urandom % 4) != 0);
      #1;
      rg = bus3.o_Grant;
      check("rnd_grant_invalid", rg & ~rv, 0);
      check("rnd_grant_onehot", $countones(rg) <= 1, 1);
      if (bus3.o_Valid && bus3.i_Grant) begin
        check("rnd_tag", bus3.o_Data[15:12], bus3.o_SrcId);
        check("rnd_seq", bus3.o_Data[11:0], 12'(outs[bus3.o_SrcId]));
        outs[bus3.o_SrcId]++;
      end
      for (int k = 0; k < N; k++) begin
        if (rg[k]) begin
          pops[k]++;
          starve[k] = 0;
        end else if (rv[k] && rg != '0) begin
          starve[k]++;
          if (starve[k] > max_starve) max_starve = starve[k];
        end
      end
      for (int k = 0; k < N; k++) begin
        if (rg[k] || !rv[k]) rv[k] = 1'($urandom % 2);
      end
    end
    total_out = 0;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rnd_count_src%0d", k), outs[k], pops[k]);
      total_out += outs[k];
    end
    check("rnd_starvation", max_starve <= N * 3, 1);
    check("rnd_progress", total_out > 500, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
